// File: rtl/flash_led_display_if.sv
// Response-byte channel from the SPI flash reader into the LED display block.
interface flash_led_display_if;
    logic [7:0] byte_in;
    logic       byte_valid;

    modport master (output byte_in, output byte_valid);
    modport slave  (input  byte_in, input  byte_valid);
endinterface

// File: rtl/flash_led_display.sv
// Captures flash response bytes into a 4-entry history and scans them onto an
// 8x4 active-low LED matrix, with a saturating capture count and a sticky ID-mismatch flag.
module flash_led_display #(
    parameter int unsigned SCAN_DIV = 12000,
    parameter logic [7:0]  EXPECTED = 8'h16
) (
    input  logic                top_clk,
    input  logic                rst,
    flash_led_display_if.slave  rsp,
    output logic [7:0]          led_col,
    output logic [3:0]          led_row,
    output logic [7:0]          last_byte,
    output logic [7:0]          capture_count,
    output logic                mismatch
);

    localparam int unsigned         CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]    SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    SCAN_ONE  = CNT_W'(1);

    logic [7:0]       h_q [4];
    logic [7:0]       h_d [4];
    logic [7:0]       count_q,    count_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       row_idx_q,  row_idx_d;
    logic [3:0]       led_row_q,  led_row_d;
    logic [7:0]       led_col_q,  led_col_d;

    // Capture path: history shift, saturating count, sticky compare.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        h_d        = h_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        if (rsp.byte_valid) begin
            h_d[3] = h_q[2];
            h_d[2] = h_q[1];
            h_d[1] = h_q[0];
            h_d[0] = rsp.byte_in;
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
            if (rsp.byte_in != EXPECTED) begin
                mismatch_d = 1'b1;
            end
        end
    end

    // Scan path: outputs are computed from the current scan position and the
    // registered history, so they trail scan_cnt/row_idx by one cycle and the
    // column drive is blanked for the first cycle of every row.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_ONE;
        row_idx_d  = row_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            row_idx_d  = row_idx_q + 2'd1;
        end
        led_row_d = ~(4'b0001 << row_idx_q);
        led_col_d = (scan_cnt_q == '0) ? 8'hFF : ~h_q[row_idx_q];
    end

    always_ff @(posedge top_clk or posedge rst) begin
        if (rst) begin
            // NOTE: the history is a handful of flops whose value is visible on last_byte, so it is reset like any other state.
            for (int i = 0; i < 4; i++) begin
                h_q[i] <= 8'h00;
            end
            count_q    <= 8'h00;
            mismatch_q <= 1'b0;
            scan_cnt_q <= '0;
            row_idx_q  <= 2'd0;
            led_row_q  <= 4'hF;
            led_col_q  <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
            h_q        <= h_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            scan_cnt_q <= scan_cnt_d;
            row_idx_q  <= row_idx_d;
            led_row_q  <= led_row_d;
            led_col_q  <= led_col_d;
        end
    end

    assign led_col       = led_col_q;
    assign led_row       = led_row_q;
    assign last_byte     = h_q[0];
    assign capture_count = count_q;
    assign mismatch      = mismatch_q;

endmodule

// File: tb/tb_flash_led_display.sv
// Directed plus randomized bench for flash_led_display, run at SCAN_DIV=4 and SCAN_DIV=2
// side by side against a cycle-count based reference model.
module tb_flash_led_display;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flash_led_display_if bus();

    logic [7:0] col4, lb4, cc4;
    logic [3:0] row4;
    logic       mm4;
    logic [7:0] col2, lb2, cc2;
    logic [3:0] row2;
    logic       mm2;

    flash_led_display #(.SCAN_DIV(4), .EXPECTED(8'h16)) dut4 (
        .top_clk(clk), .rst(rst), .rsp(bus),
        .led_col(col4), .led_row(row4), .last_byte(lb4),
        .capture_count(cc4), .mismatch(mm4)
    );

    flash_led_display #(.SCAN_DIV(2), .EXPECTED(8'h16)) dut2 (
        .top_clk(clk), .rst(rst), .rsp(bus),
        .led_col(col2), .led_row(row2), .last_byte(lb2),
        .capture_count(cc2), .mismatch(mm2)
    );

    // Reference model: history as a plain array, edges counted since reset release.
    logic [7:0] hist [4];
    int         cnt;
    bit         mm;
    int         edges;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [3:0] exp_row(int d, int e);
        return ~(4'b0001 << ((e / d) % 4));
    endfunction

    function automatic logic [7:0] exp_col(int d, int e);
        if (e % d == 0) return 8'hFF;
        return ~hist[(e / d) % 4];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = 8'h00;
        cnt   = 0;
        mm    = 1'b0;
        edges = 0;
    endtask

    task automatic check_in_reset(string tag);
        check({tag, "_row4"}, row4, 4'hF);
        check({tag, "_col4"}, col4, 8'hFF);
        check({tag, "_cnt4"}, cc4, 8'h00);
        check({tag, "_mm4"},  mm4, 1'b0);
        check({tag, "_lb4"},  lb4, 8'h00);
        check({tag, "_row2"}, row2, 4'hF);
        check({tag, "_col2"}, col2, 8'hFF);
    endtask

    // One clock: drive inputs, predict outputs from the pre-edge model, compare #1 after the edge.
    task automatic tick(input logic v, input logic [7:0] b);
        logic [3:0] r4, r2;
        logic [7:0] c4, c2;
        bus.byte_valid = v;
        bus.byte_in    = b;
        r4 = exp_row(4, edges);
        c4 = exp_col(4, edges);
        r2 = exp_row(2, edges);
        c2 = exp_col(2, edges);
        @(posedge clk);
        if (v) begin
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = b;
            if (cnt < 255) cnt++;
            if (b != 8'h16) mm = 1'b1;
        end
        edges++;
        #1;
        check("row4", row4, r4);
        check("col4", col4, c4);
        check("row2", row2, r2);
        check("col2", col2, c2);
        check("last4", lb4, hist[0]);
        check("last2", lb2, hist[0]);
        check("count4", cc4, cnt[7:0]);
        check("count2", cc2, cnt[7:0]);
        check("mism4", mm4, mm);
        check("mism2", mm2, mm);
    endtask

    // Asynchronous reset asserted between edges, held across two edges, released between edges.
    task automatic do_reset(string tag);
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        #2 rst = 1'b1;
        #1 check_in_reset({tag, "_async"});
        @(posedge clk);
        @(posedge clk);
        #1 check_in_reset({tag, "_held"});
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] rb;
        rst            = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        model_reset();
        #12 check_in_reset("por");
        #1 rst = 1'b0;

        // First edge after release selects row 0 with a blank column.
        tick(1'b0, 8'h00);
        check("first_row", row4, 4'b1110);
        check("first_blank", col4, 8'hFF);

        // Back-to-back capture and full row scan.
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        check("shift_last", lb4, 8'h44);
        check("shift_count", cc4, 8'd4);
        for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);

        // Mid-scan reset with non-zero history, then mismatch behaviour.
        do_reset("midscan");
        tick(1'b1, 8'h16);
        check("mm_match", mm4, 1'b0);
        tick(1'b1, 8'h17);
        check("mm_set", mm4, 1'b1);
        tick(1'b1, 8'h16);
        check("mm_sticky", mm4, 1'b1);

        // Saturation of the capture count.
        do_reset("sat");
        for (int i = 0; i < 300; i++) tick(1'b1, 8'h16);
        check("sat_count", cc4, 8'd255);
        check("sat_mm", mm4, 1'b0);
        check("sat_last", lb4, 8'h16);

        // Capture on the cycle the scan wraps from row 3 into row 0.
        for (int i = 0; i < 16 && (edges % 16) != 15; i++) tick(1'b0, 8'h00);
        tick(1'b1, 8'hA5);
        tick(1'b0, 8'h00);
        check("coin_row", row4, 4'b1110);
        check("coin_blank", col4, 8'hFF);
        tick(1'b0, 8'h00);
        check("coin_col", col4, 8'h5A);

        // Randomized traffic against the model.
        do_reset("rand");
        for (int i = 0; i < 200; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? 8'h16 : 8'($urandom);
            tick(1'($urandom_range(0, 1)), rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
